// File: rtl/cvxif_copro_pkg.sv
// Shared constants and types for the CV-X-IF custom coprocessor:
// instruction encoding, op codes, per-op latencies and FSM states.
package cvxif_copro_pkg;

  localparam int TRANS_ID_BITS = 4;
  localparam int CNT_W         = 3;

  localparam logic [6:0] OPCODE_COPRO = 7'b0001011;
  localparam logic [6:0] FUNCT7_COPRO = 7'b0000000;
  localparam logic [5:0] EXCCODE_ILLEGAL = 6'd2;

  typedef enum logic [2:0] {
    OP_CADD = 3'b000,
    OP_CMUL = 3'b001,
    OP_CNOP = 3'b010,
    OP_CEXC = 3'b011
  } copro_op_e;

  localparam logic [CNT_W-1:0] LAT_CADD = 3'd1;
  localparam logic [CNT_W-1:0] LAT_CMUL = 3'd4;
  localparam logic [CNT_W-1:0] LAT_CNOP = 3'd1;
  localparam logic [CNT_W-1:0] LAT_CEXC = 3'd1;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    EXEC        = 2'd1,
    WAIT_COMMIT = 2'd2,
    RESP        = 2'd3
  } copro_state_e;

  function automatic logic op_writes_rd(copro_op_e op);
    return (op == OP_CADD) || (op == OP_CMUL);
  endfunction

endpackage

// File: rtl/cvxif_copro_decode.sv
// Combinational decode of an offered instruction: accept/writeback
// response plus the op and its execution latency.
module cvxif_copro_decode
  import cvxif_copro_pkg::*;
(
  input  logic [31:0]      instr_i,
  output logic             accept_o,
  output logic             writeback_o,
  output copro_op_e        op_o,
  output logic [CNT_W-1:0] latency_o
);

  // Register-index fields are handled by the top, not by decode.
  logic unused_fields;
  assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

  always_comb begin
    accept_o    = 1'b0;
    writeback_o = 1'b0;
    op_o        = OP_CNOP;
    latency_o   = LAT_CNOP;
    if (instr_i[6:0] == OPCODE_COPRO && instr_i[31:25] == FUNCT7_COPRO) begin
      case (instr_i[14:12])
        3'b000: begin
          accept_o  = 1'b1;
          op_o      = OP_CADD;
          latency_o = LAT_CADD;
        end
        3'b001: begin
          accept_o  = 1'b1;
          op_o      = OP_CMUL;
          latency_o = LAT_CMUL;
        end
        3'b010: begin
          accept_o  = 1'b1;
          op_o      = OP_CNOP;
          latency_o = LAT_CNOP;
        end
        3'b011: begin
          accept_o  = 1'b1;
          op_o      = OP_CEXC;
          latency_o = LAT_CEXC;
        end
        default: accept_o = 1'b0;
      endcase
    end
    writeback_o = accept_o && op_writes_rd(op_o);
  end

endmodule

// File: rtl/cvxif_copro.sv
// Single-outstanding CV-X-IF coprocessor: issue, fixed-latency execute,
// wait for commit, then present the result until accepted.
module cvxif_copro
  import cvxif_copro_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int IdWidth = TRANS_ID_BITS
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [XLEN-1:0]    issue_rs1_i,
  input  logic [XLEN-1:0]    issue_rs2_i,
  output logic               issue_accept_o,
  output logic               issue_writeback_o,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [XLEN-1:0]    result_data_o,
  output logic [4:0]         result_rd_o,
  output logic               result_we_o,
  output logic               result_exc_o,
  output logic [5:0]         result_exccode_o
);

  copro_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              committed_q, committed_d;
  logic [IdWidth-1:0] id_q, id_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic              we_q, we_d;
  logic              exc_q, exc_d;

  logic              dec_accept;
  logic              dec_writeback;
  copro_op_e         dec_op;
  logic [CNT_W-1:0]  dec_latency;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN-1:0]   issue_result;
  logic              issue_commit;
  logic              commit_hit;

  cvxif_copro_decode u_decode (
    .instr_i     (issue_instr_i),
    .accept_o    (dec_accept),
    .writeback_o (dec_writeback),
    .op_o        (dec_op),
    .latency_o   (dec_latency)
  );

  assign issue_accept_o    = dec_accept;
  assign issue_writeback_o = dec_writeback;
  assign issue_ready_o     = (state_q == IDLE) && !rst_i;

  // The result is computed at issue; the latency only models pipeline depth.
  assign mul_res = issue_rs1_i * issue_rs2_i;

  always_comb begin
    issue_result = '0;
    case (dec_op)
      OP_CADD: issue_result = issue_rs1_i + issue_rs2_i;
      OP_CMUL: issue_result = mul_res;
      default: issue_result = '0;
    endcase
  end

  // A commit can arrive alongside the issue, before the ID is stored.
  assign issue_commit = commit_valid_i && (commit_id_i == issue_id_i);
  assign commit_hit   = commit_valid_i && (commit_id_i == id_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    committed_d = committed_q;
    id_d        = id_q;
    rd_d        = rd_q;
    data_d      = data_q;
    we_d        = we_q;
    exc_d       = exc_q;
    if (flush_i) begin
      state_d     = IDLE;
      cnt_d       = '0;
      committed_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (issue_valid_i && issue_ready_o && dec_accept &&
              !(issue_commit && commit_kill_i)) begin
            state_d     = EXEC;
            cnt_d       = dec_latency;
            committed_d = issue_commit;
            id_d        = issue_id_i;
            rd_d        = issue_instr_i[11:7];
            data_d      = issue_result;
            we_d        = dec_writeback;
            exc_d       = (dec_op == OP_CEXC);
          end
        end
        EXEC: begin
          if (commit_hit && commit_kill_i) begin
            state_d     = IDLE;
            cnt_d       = '0;
            committed_d = 1'b0;
          end else begin
            committed_d = committed_q | commit_hit;
            if (cnt_q <= CNT_W'(1)) begin
              cnt_d   = '0;
              state_d = committed_d ? RESP : WAIT_COMMIT;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        WAIT_COMMIT: begin
          if (commit_hit) begin
            if (commit_kill_i) begin
              state_d     = IDLE;
              committed_d = 1'b0;
            end else begin
              state_d     = RESP;
              committed_d = 1'b1;
            end
          end
        end
        RESP: begin
          if ((commit_hit && commit_kill_i) || result_ready_i) begin
            state_d     = IDLE;
            committed_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      committed_q <= 1'b0;
      id_q        <= '0;
      rd_q        <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      exc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      committed_q <= committed_d;
      id_q        <= id_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
      we_q        <= we_d;
      exc_q       <= exc_d;
    end
  end

  assign result_valid_o   = (state_q == RESP);
  assign result_id_o      = id_q;
  assign result_data_o    = data_q;
  assign result_rd_o      = rd_q;
  assign result_we_o      = we_q;
  assign result_exc_o     = exc_q;
  assign result_exccode_o = exc_q ? EXCCODE_ILLEGAL : 6'd0;

endmodule

// File: tb/tb_cvxif_copro.sv
// Randomized bench for cvxif_copro: transactions are scored against
// timing/result rules computed directly from op, operands and commit cycle.
module tb_cvxif_copro;
  import cvxif_copro_pkg::*;

  localparam int XLEN = 32;
  localparam int IW   = TRANS_ID_BITS;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          flush_i;
  logic          issue_valid_i;
  logic          issue_ready_o;
  logic [31:0]   issue_instr_i;
  logic [IW-1:0] issue_id_i;
  logic [XLEN-1:0] issue_rs1_i;
  logic [XLEN-1:0] issue_rs2_i;
  logic          issue_accept_o;
  logic          issue_writeback_o;
  logic          commit_valid_i;
  logic [IW-1:0] commit_id_i;
  logic          commit_kill_i;
  logic          result_valid_o;
  logic          result_ready_i;
  logic [IW-1:0] result_id_o;
  logic [XLEN-1:0] result_data_o;
  logic [4:0]    result_rd_o;
  logic          result_we_o;
  logic          result_exc_o;
  logic [5:0]    result_exccode_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cvxif_copro #(.XLEN(XLEN), .IdWidth(IW)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .flush_i          (flush_i),
    .issue_valid_i    (issue_valid_i),
    .issue_ready_o    (issue_ready_o),
    .issue_instr_i    (issue_instr_i),
    .issue_id_i       (issue_id_i),
    .issue_rs1_i      (issue_rs1_i),
    .issue_rs2_i      (issue_rs2_i),
    .issue_accept_o   (issue_accept_o),
    .issue_writeback_o(issue_writeback_o),
    .commit_valid_i   (commit_valid_i),
    .commit_id_i      (commit_id_i),
    .commit_kill_i    (commit_kill_i),
    .result_valid_o   (result_valid_o),
    .result_ready_i   (result_ready_i),
    .result_id_o      (result_id_o),
    .result_data_o    (result_data_o),
    .result_rd_o      (result_rd_o),
    .result_we_o      (result_we_o),
    .result_exc_o     (result_exc_o),
    .result_exccode_o (result_exccode_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [6:0] opc);
    return {f7, 5'd3, 5'd2, f3, rd, opc};
  endfunction

  // Reference results straight from the op definitions (64-bit product, low half kept).
  function automatic logic [31:0] ref_result(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      0: return a + b;
      1: return p[31:0];
      default: return 32'd0;
    endcase
  endfunction

  task automatic idle_inputs();
    issue_valid_i  = 1'b0;
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
    flush_i        = 1'b0;
    result_ready_i = 1'b0;
  endtask

  // commit_at = -1 means commit together with the issue. Cycle n is the n-th
  // clock period after the issue edge. flush_at < 0 means no flush.
  task automatic run_txn(input int op, input logic [31:0] a, input logic [31:0] b,
                         input logic [IW-1:0] id, input logic [4:0] rd, input int commit_at,
                         input bit kill, input int rdelay, input int flush_at, input bit noise);
    int lat;
    int ev;
    int busy_end;
    bit exp_valid;
    bit exp_ready;
    logic [IW-1:0] wrong_id;
    lat      = (op == 1) ? 4 : 1;
    ev       = (commit_at + 1 > lat) ? commit_at + 1 : lat;
    busy_end = kill ? commit_at : ev + rdelay;
    if (!kill && flush_at >= 0 && flush_at <= busy_end) busy_end = flush_at;
    wrong_id = id + IW'(1);

    @(negedge clk);
    issue_valid_i  = 1'b1;
    issue_instr_i  = mk_instr(7'd0, 3'(op), rd, 7'b0001011);
    issue_id_i     = id;
    issue_rs1_i    = a;
    issue_rs2_i    = b;
    commit_valid_i = (commit_at < 0);
    commit_id_i    = id;
    commit_kill_i  = 1'b0;
    flush_i        = 1'b0;
    result_ready_i = 1'b0;
    #1;
    check("issue_ready@issue", issue_ready_o, 1);
    check("accept", issue_accept_o, 1);
    check("writeback", issue_writeback_o, (op < 2));
    check("valid@issue", result_valid_o, 0);

    for (int n = 0; n <= busy_end + 1; n++) begin
      @(negedge clk);
      issue_valid_i  = 1'b0;
      flush_i        = (n == flush_at);
      result_ready_i = (n >= ev + rdelay);
      if (n == commit_at) begin
        commit_valid_i = 1'b1;
        commit_id_i    = id;
        commit_kill_i  = kill;
      end else if (noise && n < busy_end && $urandom_range(0, 2) == 0) begin
        commit_valid_i = 1'b1;
        commit_id_i    = wrong_id;
        commit_kill_i  = 1'($urandom_range(0, 1));
      end else begin
        commit_valid_i = 1'b0;
        commit_kill_i  = 1'b0;
      end
      #1;
      exp_valid = !kill && n >= ev && n <= busy_end;
      exp_ready = n > busy_end;
      check("result_valid", result_valid_o, exp_valid);
      check("issue_ready", issue_ready_o, exp_ready);
      if (exp_valid) begin
        check("result_id", result_id_o, id);
        check("result_rd", result_rd_o, rd);
        check("result_we", result_we_o, (op < 2));
        check("result_exc", result_exc_o, (op == 3));
        check("result_exccode", result_exccode_o, (op == 3) ? 2 : 0);
        if (op != 3) check("result_data", result_data_o, ref_result(op, a, b));
      end
    end
    idle_inputs();
    $display("txn op=%0d a=%08h b=%08h id=%0d rd=%0d commit@%0d kill=%0b rdly=%0d flush@%0d",
             op, a, b, id, rd, commit_at, kill, rdelay, flush_at);
  endtask

  task automatic run_illegal(input logic [31:0] instr);
    @(negedge clk);
    issue_valid_i  = 1'b1;
    issue_instr_i  = instr;
    issue_id_i     = IW'($urandom_range(0, 15));
    commit_valid_i = 1'b0;
    #1;
    check("illegal_accept", issue_accept_o, 0);
    check("illegal_writeback", issue_writeback_o, 0);
    check("illegal_ready", issue_ready_o, 1);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      issue_valid_i = 1'b0;
      #1;
      check("illegal_no_valid", result_valid_o, 0);
      check("illegal_ready_after", issue_ready_o, 1);
    end
    $display("txn illegal instr=%08h", instr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    int c_at;
    bit kl;
    int fl;
    idle_inputs();
    issue_instr_i = '0;
    issue_id_i    = '0;
    issue_rs1_i   = '0;
    issue_rs2_i   = '0;
    commit_id_i   = '0;
    rst_i         = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", issue_ready_o, 0);
    check("rst_valid", result_valid_o, 0);
    check("rst_data", result_data_o, 0);
    check("rst_id", result_id_o, 0);
    check("rst_we", result_we_o, 0);
    check("rst_exc", result_exc_o, 0);
    rst_i = 1'b0;

    run_txn(0, 32'd5, 32'd7, IW'(3), 5'd9, -1, 1'b0, 0, -1, 1'b0);
    run_txn(1, 32'hFFFF_FFFF, 32'd2, IW'(5), 5'd1, 1, 1'b0, 0, -1, 1'b0);
    run_txn(0, 32'd100, 32'd23, IW'(6), 5'd4, 6, 1'b0, 3, -1, 1'b1);
    run_txn(1, 32'd3, 32'd4, IW'(2), 5'd7, 2, 1'b1, 0, -1, 1'b0);
    run_illegal(mk_instr(7'd0, 3'd0, 5'd5, 7'b0110011));
    run_txn(3, 32'd1, 32'd1, IW'(7), 5'd2, 0, 1'b0, 0, -1, 1'b0);
    run_txn(0, 32'd1, 32'd2, IW'(1), 5'd3, -1, 1'b0, 4, 2, 1'b0);

    // Reset pulsed while a CMUL is in EXEC.
    @(negedge clk);
    issue_valid_i  = 1'b1;
    issue_instr_i  = mk_instr(7'd0, 3'd1, 5'd8, 7'b0001011);
    issue_id_i     = IW'(4);
    issue_rs1_i    = 32'd9;
    issue_rs2_i    = 32'd9;
    commit_valid_i = 1'b1;
    commit_id_i    = IW'(4);
    @(negedge clk);
    idle_inputs();
    #1;
    check("exec_ready", issue_ready_o, 0);
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    check("midrst_ready", issue_ready_o, 0);
    check("midrst_valid", result_valid_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      #1;
      check("postrst_valid", result_valid_o, 0);
      check("postrst_ready", issue_ready_o, 1);
    end
    $display("txn reset during EXEC");

    for (int t = 0; t < 40; t++) begin
      op = int'($urandom_range(0, 4));
      if (op == 4) begin
        case ($urandom_range(0, 2))
          0: run_illegal(mk_instr(7'd0, 3'($urandom_range(4, 7)), 5'($urandom), 7'b0001011));
          1: run_illegal(mk_instr(7'($urandom_range(1, 127)), 3'($urandom_range(0, 3)), 5'($urandom), 7'b0001011));
          default: run_illegal(mk_instr(7'd0, 3'd0, 5'($urandom), 7'b0110011));
        endcase
      end else begin
        c_at = int'($urandom_range(0, 7)) - 1;
        kl   = (c_at >= 0) && ($urandom_range(0, 4) == 0);
        fl   = (!kl && $urandom_range(0, 7) == 0) ? int'($urandom_range(0, 8)) : -1;
        run_txn(op, $urandom, $urandom, IW'($urandom), 5'($urandom), c_at, kl,
                int'($urandom_range(0, 3)), fl, 1'b1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cvxif_copro.md
CVXIF_COPRO -- requirements
Module: cvxif_copro

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand and result width.
REQ-002 SHALL have parameter IdWidth, default TRANS_ID_BITS, meaning width of the scoreboard transaction ID.
REQ-003 SHALL have port clk_i, input, 1 bit: the only clock; all logic is rising-edge.
REQ-004 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port flush_i, input, 1 bit: pipeline flush.
REQ-006 SHALL have ports issue_valid_i (in, 1) and issue_ready_o (out, 1): issue handshake.
REQ-007 SHALL have ports issue_instr_i (in, 32), issue_id_i (in, IdWidth), issue_rs1_i (in, XLEN), issue_rs2_i (in, XLEN): issued instruction, its ID and source operands.
REQ-008 SHALL have ports issue_accept_o (out, 1) and issue_writeback_o (out, 1): combinational decode response, meaningful only during the issue handshake.
REQ-009 SHALL have ports commit_valid_i (in, 1), commit_id_i (in, IdWidth), commit_kill_i (in, 1): commit or kill of an outstanding ID.
REQ-010 SHALL have ports result_valid_o (out, 1) and result_ready_i (in, 1): result handshake.
REQ-011 SHALL have ports result_id_o (out, IdWidth), result_data_o (out, XLEN), result_rd_o (out, 5), result_we_o (out, 1), result_exc_o (out, 1), result_exccode_o (out, 6): result payload.

Function
REQ-012 SHALL accept only opcode 7'b0001011 with funct7 = 0: funct3 000 CADD (rs1+rs2, latency 1), 001 CMUL (low XLEN bits of rs1*rs2, latency 4), 010 CNOP (no writeback, latency 1), 011 CEXC (latency 1, exception).
REQ-013 SHALL drive issue_accept_o=0 and issue_writeback_o=0 for every other encoding; the handshake still completes, nothing is stored, and the state stays IDLE.
REQ-014 SHALL drive issue_writeback_o=1 only for CADD and CMUL.
REQ-015 SHALL use the FSM states IDLE, EXEC, WAIT_COMMIT and RESP, with one outstanding instruction at most; issue_ready_o = (state==IDLE) and !rst_i.
REQ-016 SHALL, on an accepted issue handshake, register the ID, rd (instr[11:7]), op, result and latency counter, then go to EXEC.
REQ-017 SHALL decrement the counter in EXEC; when the counter expires it goes to RESP if commit has already been seen, otherwise to WAIT_COMMIT.
REQ-018 SHALL assert result_valid_o L cycles after the issue edge when commit arrives no later than that, otherwise 1 cycle after the commit edge.
REQ-019 SHALL count a commit (commit_valid_i with commit_id_i equal to the stored ID) in any non-IDLE state, including the issue cycle itself, and latch it.
REQ-020 SHALL ignore commits whose ID does not match the stored ID.
REQ-021 SHALL, when a matching commit has commit_kill_i=1, go to IDLE on the next edge and produce no result.
REQ-022 SHALL, in RESP, hold every result payload field stable until result_valid_o & result_ready_i, then go to IDLE; a new issue is accepted no earlier than the following cycle.
REQ-023 SHALL drive result payloads per op: CADD/CMUL result_we_o=1; CNOP result_we_o=0, data 0; CEXC result_exc_o=1, result_exccode_o=2 (illegal instruction), result_we_o=0.
REQ-024 SHALL, on flush_i in any state (including RESP mid-backpressure), go to IDLE on the next edge, clear the commit latch and counter, and deassert result_valid_o from that edge.
REQ-025 SHALL give flush_i priority over issue, commit and the result handshake occurring in the same cycle.
REQ-026 SHALL wrap all arithmetic modulo 2^XLEN.

Reset
REQ-027 SHALL, while rst_i is high, force state=IDLE, result_valid_o=0, issue_ready_o=0, and all registered payloads, counter and commit latch to 0.
REQ-028 SHALL abort any in-flight operation when rst_i asserts mid-operation, with no result emitted afterwards.

Structure
REQ-029 SHALL place the opcode constant, funct3 op enum, per-op latency constants and FSM state enum in the shared package cvxif_copro_pkg.
REQ-030 SHALL implement decode (accept, writeback, op, latency) as the combinational sub-module cvxif_copro_decode.

Verification
REQ-031 SHALL cover: CADD id=3, rs1=5, rs2=7, commit in the same cycle, result_ready_i=1 -> result_valid_o one cycle later with data=12, rd from instr, we=1, id=3.
REQ-032 SHALL cover: CMUL rs1=0xFFFFFFFF, rs2=2, commit at cycle 1 -> result_valid_o at cycle 4, data=0xFFFFFFFE.
REQ-033 SHALL cover: CADD with commit delayed to cycle 6 -> result_valid_o at cycle 7; result_ready_i=0 for 3 cycles -> payload stable, issue_ready_o=0 throughout.
REQ-034 SHALL cover: CMUL with kill at cycle 2 -> no result_valid_o; issue_ready_o=1 at cycle 3.
REQ-035 SHALL cover: opcode 0110011 issued -> issue_accept_o=0, issue_ready_o stays 1, no result; then CEXC -> result_exc_o=1, exccode=2, we=0.
REQ-036 SHALL cover: flush_i in RESP with result_ready_i=0, then rst_i pulsed during EXEC -> result_valid_o=0 next edge and no stale result after either event.
